blctrl_scheduler: RTL and testbench

BLCTRL_SCHEDULER -- requirements
Module: blctrl_scheduler

---
 rtl/blctrl_pkg.sv | 28 ++
 rtl/blctrl_gap_timer.sv | 34 +++
 rtl/blctrl_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_blctrl_scheduler.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blctrl_pkg.sv
// Shared types, constants and the round-robin pick helper for the BLDC I2C scheduler.
package blctrl_pkg;

    localparam int NUM_MOTORS = 8;
    localparam logic [6:0] DEFAULT_BASE_ADDR = 7'h29;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CMD,
        DATA,
        WAIT_DONE,
        GAP
    } state_e;

    // Returns {found, index}: first set bit after 'last', ascending with wrap; 'last' itself ranks lowest.
    function automatic logic [3:0] pick_next(input logic [NUM_MOTORS-1:0] elig, input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] k;
        res = '0;
        for (int off = NUM_MOTORS; off >= 1; off--) begin
            k = last + 3'(off);
            if (elig[k]) res = {1'b1, k};
        end
        return res;
    endfunction

endpackage

// File: rtl/blctrl_gap_timer.sv
// Down-counter that times the idle gap between motor transfers; done when it reaches zero.
module blctrl_gap_timer #(
    parameter int GAP_CYCLES = 480
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam int W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    // The load cycle itself is the first gap cycle, so the count starts one short.
    localparam logic [W-1:0] LOAD_VAL = W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/blctrl_scheduler.sv
// Round-robin I2C speed scheduler for eight BLDC motor controllers.
// Optional ACK fault tracking is built when BLCTRL_ACK_FAULT_EN is defined.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for master_enable and an eligible motor
//   SELECT    | pick next eligible motor, latch its index and speed
//   CMD       | present write+stop command to the i2c master
//   DATA      | present the single speed byte
//   WAIT_DONE | wait for the bus to go idle and the master to be ready
//   GAP       | idle spacing before the next selection
module blctrl_scheduler
    import blctrl_pkg::*;
#(
    parameter logic [6:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int         GAP_CYCLES  = 480,
    parameter int         FAULT_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        master_enable,
    input  logic [7:0]  motor_enable,
    input  logic [63:0] target_speed_flat,
    output logic [6:0]  cmd_address,
    output logic        cmd_start,
    output logic        cmd_read,
    output logic        cmd_write,
    output logic        cmd_write_multiple,
    output logic        cmd_stop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  data_tdata,
    output logic        data_tvalid,
    input  logic        data_tready,
    output logic        data_tlast,
    input  logic        i2c_busy,
    input  logic        missed_ack,
    output logic [7:0]  fault_flags,
    output logic [2:0]  current_motor,
    output logic        cycle_done
);

    state_e     state_q, state_d;
    logic [2:0] last_q, last_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] speed_q, speed_d;
    logic       cycle_done_q, cycle_done_d;

    logic [7:0] elig;
    logic [3:0] pick;
    logic [7:0] speed_pick;
    logic       gap_load, gap_count, gap_done;
    logic       xfer_end;

    assign elig       = motor_enable & ~fault_flags;
    assign pick       = pick_next(elig, last_q);
    assign speed_pick = target_speed_flat[{3'd7 - pick[2:0], 3'b000} +: 8];

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        idx_d        = idx_q;
        speed_d      = speed_q;
        cycle_done_d = 1'b0;
        gap_load     = 1'b0;
        gap_count    = 1'b0;
        xfer_end     = 1'b0;
        case (state_q)
            IDLE: begin
                if (master_enable && (elig != '0)) state_d = SELECT;
            end
            SELECT: begin
                if (master_enable && pick[3]) begin
                    idx_d   = pick[2:0];
                    last_d  = pick[2:0];
                    speed_d = speed_pick;
                    state_d = CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                if (cmd_ready) state_d = DATA;
            end
            DATA: begin
                if (data_tready) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!i2c_busy && cmd_ready) begin
                    xfer_end = 1'b1;
                    if (master_enable) begin
                        state_d      = GAP;
                        gap_load     = 1'b1;
                        // End of a sweep: nothing eligible above the motor just served.
                        cycle_done_d = ((elig & (8'hFE << idx_q)) == '0);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                gap_count = 1'b1;
                if (gap_done) state_d = SELECT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= 3'd7;
            idx_q        <= 3'd0;
            speed_q      <= 8'd0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            speed_q      <= speed_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    blctrl_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (gap_load),
        .count (gap_count),
        .done  (gap_done)
    );

`ifdef BLCTRL_ACK_FAULT_EN
    logic                         fail_q, fail_d;
    logic [NUM_MOTORS-1:0][1:0]   miss_q, miss_d;
    logic [7:0]                   fault_q, fault_d;

    always_comb begin
        fail_d  = fail_q;
        miss_d  = miss_q;
        fault_d = fault_q;
        if (state_q == SELECT) begin
            fail_d = 1'b0;
        end else if (state_q inside {CMD, DATA, WAIT_DONE}) begin
            fail_d = fail_q | missed_ack;
        end
        if (xfer_end) begin
            if (fail_q | missed_ack) begin
                if (miss_q[idx_q] != 2'd3) miss_d[idx_q] = miss_q[idx_q] + 2'd1;
                if (int'(miss_q[idx_q]) + 1 >= FAULT_LIMIT) fault_d[idx_q] = 1'b1;
            end else begin
                miss_d[idx_q] = 2'd0;
            end
        end
        // A disabled motor gets a fresh start when it is re-enabled.
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (!motor_enable[i]) begin
                miss_d[i]  = 2'd0;
                fault_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_q  <= 1'b0;
            miss_q  <= '0;
            fault_q <= '0;
        end else begin
            fail_q  <= fail_d;
            miss_q  <= miss_d;
            fault_q <= fault_d;
        end
    end

    assign fault_flags = fault_q;
`else
    logic unused_fault_inputs;
    assign unused_fault_inputs = missed_ack ^ xfer_end ^ (FAULT_LIMIT > 3);
    assign fault_flags = '0;
`endif

    assign cmd_valid          = (state_q == CMD);
    assign cmd_write          = cmd_valid;
    assign cmd_stop           = cmd_valid;
    assign cmd_start          = 1'b0;
    assign cmd_read           = 1'b0;
    assign cmd_write_multiple = 1'b0;
    assign cmd_address        = BASE_ADDR + {4'd0, idx_q};
    assign data_tvalid        = (state_q == DATA);
    assign data_tlast         = data_tvalid;
    assign data_tdata         = speed_q;
    assign current_motor      = idx_q;
    assign cycle_done         = cycle_done_q;

endmodule

// File: tb/tb_blctrl_scheduler.sv
// Randomized self-checking bench for blctrl_scheduler with an i2c_master responder and transfer-order model.
module tb_blctrl_scheduler;

    localparam int         GAP  = 480;
    localparam logic [7:0] BASE = 8'h29;

    logic        clk;
    logic        rst_n;
    logic        master_enable;
    logic [7:0]  motor_enable;
    logic [7:0]  spd [8];
    logic [63:0] target_speed_flat;
    logic [6:0]  cmd_address;
    logic        cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid;
    logic        cmd_ready;
    logic [7:0]  data_tdata;
    logic        data_tvalid, data_tready, data_tlast;
    logic        i2c_busy, missed_ack;
    logic [7:0]  fault_flags;
    logic [2:0]  current_motor;
    logic        cycle_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_until;
    bit rand_mode;
    logic [7:0] miss_addr;

    int cmd_q[$], data_q[$], cd_q[$], rise_q[$];
    int bad_flags = 0;
    int unstable = 0;

    int m_last;
    int m_miss [8];
    logic [7:0] m_fault;

    assign target_speed_flat = {spd[0], spd[1], spd[2], spd[3], spd[4], spd[5], spd[6], spd[7]};

    blctrl_scheduler dut (
        .clk(clk), .rst_n(rst_n), .master_enable(master_enable), .motor_enable(motor_enable),
        .target_speed_flat(target_speed_flat), .cmd_address(cmd_address), .cmd_start(cmd_start),
        .cmd_read(cmd_read), .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple),
        .cmd_stop(cmd_stop), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .data_tdata(data_tdata),
        .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tlast(data_tlast),
        .i2c_busy(i2c_busy), .missed_ack(missed_ack), .fault_flags(fault_flags),
        .current_motor(current_motor), .cycle_done(cycle_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // i2c_master responder: drives ready/busy/ack just after each rising edge.
    initial begin
        int seen;
        int busy;
        seen = 0;
        busy = 0;
        cmd_ready = 1'b1; data_tready = 1'b1; i2c_busy = 1'b0; missed_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (data_q.size() > seen) begin
                seen = data_q.size();
                busy = rand_mode ? int'($urandom_range(0, 6)) : 0;
            end
            i2c_busy = (busy > 0);
            if (busy > 0) busy--;
            cmd_ready = rand_mode ? (($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0) : 1'b1;
            if (cyc < stall_until) data_tready = 1'b0;
            else data_tready = rand_mode ? (($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0) : 1'b1;
            missed_ack = (miss_addr == {1'b0, cmd_address});
        end
    end

    // Monitor: records handshakes, sweep pulses, command rises and stream stability.
    logic prev_cv = 1'b0, cmd_wait = 1'b0, data_wait = 1'b0;
    logic [6:0] prev_addr = '0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            cmd_q.push_back(int'(cmd_address));
            if (!(cmd_write && cmd_stop && !cmd_start && !cmd_read && !cmd_write_multiple)) bad_flags++;
        end
        if (data_tvalid && data_tready) begin
            data_q.push_back(int'(data_tdata));
            if (!data_tlast) bad_flags++;
        end
        if (cycle_done) cd_q.push_back(cmd_q.size());
        if (cmd_valid && !prev_cv) rise_q.push_back(cyc);
        prev_cv = cmd_valid;
        if (rst_n && cmd_wait && (!cmd_valid || cmd_address !== prev_addr)) unstable++;
        if (rst_n && data_wait && (!data_tvalid || data_tdata !== prev_data)) unstable++;
        cmd_wait  = rst_n && cmd_valid && !cmd_ready;
        data_wait = rst_n && data_tvalid && !data_tready;
        prev_addr = cmd_address;
        prev_data = data_tdata;
    end

    task automatic model_reset();
        m_last  = 7;
        m_fault = '0;
        for (int i = 0; i < 8; i++) m_miss[i] = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        master_enable = 1'b0;
        stall_until = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic int model_pick(input logic [7:0] mask);
        int r;
        r = -1;
        for (int off = 1; off <= 8; off++)
            if (r < 0 && mask[(m_last + off) % 8]) r = (m_last + off) % 8;
        return r;
    endfunction

    task automatic run_and_check(input int n, input logic [7:0] mask, input int miss, input bit rnd,
                                 input string tag);
        int exp_addr[$], exp_byte[$], exp_cd[$];
        int cb, db, cdb, rb, idx, t, bu, ub;
        logic [7:0] el;
        for (int k = 0; k < n; k++) begin
            idx = model_pick(mask & ~m_fault);
            if (idx < 0) break;
            exp_addr.push_back(int'(BASE) + idx);
            exp_byte.push_back(int'(spd[idx]));
            m_last = idx;
`ifdef BLCTRL_ACK_FAULT_EN
            if (idx == miss) begin
                if (m_miss[idx] < 3) m_miss[idx]++;
                if (m_miss[idx] >= 3) m_fault[idx] = 1'b1;
            end else begin
                m_miss[idx] = 0;
            end
`endif
            el = mask & ~m_fault;
            if (k < n - 1 && (el >> (idx + 1)) == 8'd0) exp_cd.push_back(exp_addr.size());
        end
        cb = cmd_q.size(); db = data_q.size(); cdb = cd_q.size(); rb = rise_q.size();
        bu = bad_flags; ub = unstable;
        motor_enable = mask;
        rand_mode = rnd;
        miss_addr = (miss < 0) ? 8'hFF : 8'(int'(BASE) + miss);
        master_enable = 1'b1;
        t = 0;
        while (data_q.size() < db + exp_addr.size() && t < n * (GAP + 200) + 500) begin
            @(negedge clk);
            t++;
        end
        master_enable = 1'b0;
        repeat (40) @(negedge clk);
        miss_addr = 8'hFF;
        checks++;
        if (cmd_q.size() - cb != exp_addr.size() || data_q.size() - db != exp_addr.size()) begin
            errors++;
            $display("FAIL %s count: got cmds %0d bytes %0d, expected %0d", tag, cmd_q.size() - cb,
                     data_q.size() - db, exp_addr.size());
        end else begin
            for (int k = 0; k < exp_addr.size(); k++) begin
                checks++;
                if (cmd_q[cb + k] != exp_addr[k] || data_q[db + k] != exp_byte[k]) begin
                    errors++;
                    $display("FAIL %s xfer[%0d]: got addr %h byte %h, expected addr %h byte %h", tag, k,
                             cmd_q[cb + k], data_q[db + k], exp_addr[k], exp_byte[k]);
                end
            end
        end
        checks++;
        if (cd_q.size() - cdb != exp_cd.size()) begin
            errors++;
            $display("FAIL %s cycle_done count: got %0d expected %0d", tag, cd_q.size() - cdb, exp_cd.size());
        end else begin
            for (int k = 0; k < exp_cd.size(); k++) begin
                checks++;
                if (cd_q[cdb + k] - cb != exp_cd[k]) begin
                    errors++;
                    $display("FAIL %s cycle_done[%0d]: after xfer %0d, expected after %0d", tag, k,
                             cd_q[cdb + k] - cb, exp_cd[k]);
                end
            end
        end
        for (int k = rb + 1; k < rise_q.size(); k++) begin
            checks++;
            if (rise_q[k] - rise_q[k - 1] < GAP) begin
                errors++;
                $display("FAIL %s spacing: got %0d cycles, expected >= %0d", tag, rise_q[k] - rise_q[k - 1], GAP);
            end
        end
        checks++;
        if (bad_flags != bu || unstable != ub) begin
            errors++;
            $display("FAIL %s stream: got %0d flag and %0d stability violations, expected 0", tag,
                     bad_flags - bu, unstable - ub);
        end
    endtask

    task automatic test_reset();
        motor_enable = 8'h00;
        rand_mode = 0;
        miss_addr = 8'hFF;
        do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_valid, data_tvalid, data_tlast, cmd_stop, cmd_write, cmd_start, cmd_read,
             cmd_write_multiple, cycle_done} !== 9'b0) begin
            errors++;
            $display("FAIL reset controls: got %b expected 0", {cmd_valid, data_tvalid, data_tlast,
                     cmd_stop, cmd_write, cmd_start, cmd_read, cmd_write_multiple, cycle_done});
        end
        checks++;
        if (cmd_address !== 7'h29 || data_tdata !== 8'h00) begin
            errors++;
            $display("FAIL reset payload: got addr %h data %h expected 29/00", cmd_address, data_tdata);
        end
        checks++;
        if (fault_flags !== 8'h00 || current_motor !== 3'd0) begin
            errors++;
            $display("FAIL reset status: got faults %h motor %0d expected 00/0", fault_flags, current_motor);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 8; i++) spd[i] = 8'h10 + 8'(i);
        run_and_check(9, 8'hFF, -1, 0, "round_robin");
    endtask

    task automatic test_sparse();
        do_reset();
        for (int i = 0; i < 8; i++) spd[i] = 8'($urandom);
        run_and_check(4, 8'b1010_0100, -1, 0, "sparse");
    endtask

    task automatic test_speed_hold();
        int db, t;
        motor_enable = 8'h01;
        spd[0] = 8'h40;
        rand_mode = 1;
        db = data_q.size();
        master_enable = 1'b1;
        t = 0;
        while (!cmd_valid && t < 2000) begin @(negedge clk); t++; end
        @(negedge clk);
        spd[0] = 8'h80;
        t = 0;
        while (data_q.size() < db + 2 && t < 3000) begin @(negedge clk); t++; end
        master_enable = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (data_q.size() < db + 2) begin
            errors++;
            $display("FAIL speed_hold count: got %0d bytes expected 2", data_q.size() - db);
        end else begin
            checks++;
            if (data_q[db] != 32'h40 || data_q[db + 1] != 32'h80) begin
                errors++;
                $display("FAIL speed_hold bytes: got %h %h expected 40 80", data_q[db], data_q[db + 1]);
            end
        end
        m_last = 0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) spd[i] = 8'($urandom);
            run_and_check(int'($urandom_range(2, 5)), 8'($urandom_range(1, 255)), -1, 1, "random");
        end
    endtask

    task automatic test_fault();
        do_reset();
        for (int i = 0; i < 8; i++) spd[i] = 8'($urandom);
        run_and_check(28, 8'hFF, 3, 1, "fault_run");
        checks++;
        if (fault_flags !== m_fault) begin
            errors++;
            $display("FAIL fault_flags set: got %h expected %h", fault_flags, m_fault);
        end
        motor_enable[3] = 1'b0;
        @(negedge clk);
        motor_enable = 8'hFF;
        @(negedge clk);
        m_fault[3] = 1'b0;
        m_miss[3] = 0;
        checks++;
        if (fault_flags !== 8'h00) begin
            errors++;
            $display("FAIL fault_flags clear: got %h expected 00", fault_flags);
        end
        run_and_check(8, 8'hFF, -1, 1, "fault_cleared");
    endtask

    task automatic test_enable_drop();
        int cb, db, cdb, idx, t;
        motor_enable = 8'hFF;
        rand_mode = 0;
        idx = model_pick(8'hFF & ~m_fault);
        cb = cmd_q.size(); db = data_q.size(); cdb = cd_q.size();
        master_enable = 1'b1;
        t = 0;
        while (!cmd_valid && t < 2000) begin @(negedge clk); t++; end
        stall_until = cyc + 6;
        t = 0;
        while (!data_tvalid && t < 100) begin @(negedge clk); t++; end
        master_enable = 1'b0;
        repeat (700) @(negedge clk);
        checks++;
        if (cmd_q.size() - cb != 1 || data_q.size() - db != 1) begin
            errors++;
            $display("FAIL enable_drop count: got cmds %0d bytes %0d expected 1/1", cmd_q.size() - cb,
                     data_q.size() - db);
        end else begin
            checks++;
            if (cmd_q[cb] != int'(BASE) + idx || data_q[db] != int'(spd[idx])) begin
                errors++;
                $display("FAIL enable_drop xfer: got %h/%h expected %h/%h", cmd_q[cb], data_q[db],
                         int'(BASE) + idx, spd[idx]);
            end
        end
        checks++;
        if (cd_q.size() != cdb || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop idle: got %0d pulses cmd_valid %b expected 0/0", cd_q.size() - cdb, cmd_valid);
        end
        m_last = idx;
    endtask

    task automatic test_reset_mid();
        int db, t;
        motor_enable = 8'hFF;
        rand_mode = 0;
        db = data_q.size();
        master_enable = 1'b1;
        t = 0;
        while (!cmd_valid && t < 2000) begin @(negedge clk); t++; end
        stall_until = cyc + 20;
        t = 0;
        while (!data_tvalid && t < 100) begin @(negedge clk); t++; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cmd_valid !== 1'b0 || data_tvalid !== 1'b0 || fault_flags !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid valids: got cmd %b data %b faults %h expected 0/0/00", cmd_valid,
                     data_tvalid, fault_flags);
        end
        checks++;
        if (current_motor !== 3'd0 || cmd_address !== 7'h29) begin
            errors++;
            $display("FAIL reset_mid state: got motor %0d addr %h expected 0/29", current_motor, cmd_address);
        end
        @(negedge clk);
        master_enable = 1'b0;
        stall_until = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (data_q.size() != db) begin
            errors++;
            $display("FAIL reset_mid completion: got %0d bytes expected 0", data_q.size() - db);
        end
        rst_n = 1'b1;
        model_reset();
        run_and_check(3, 8'hFF, -1, 0, "after_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        master_enable = 1'b0;
        motor_enable = 8'h00;
        stall_until = 0;
        rand_mode = 0;
        miss_addr = 8'hFF;
        for (int i = 0; i < 8; i++) spd[i] = 8'h00;
        model_reset();
        test_reset();
        test_round_robin();
        test_sparse();
        test_speed_hold();
        test_random();
        test_fault();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
